sipo_deframer: RTL

Serial-to-parallel receiver that sits directly downstream of the 4-bit PISO shifter. It hunts for a start bit on the serial line, shifts in one WIDTH-bit word MSB first, and presents it on a one-entry buffered parallel output with a valid/ready handshake. Words that cannot be buffered are dropped and flagged. An optional parity check is available at compile time.

---
 rtl/sipo_deframer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: start bit, WIDTH data bits MSB first, one-entry valid/ready output buffer.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and drop words that fail it.
module sipo_deframer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             ovf,
    output logic             perr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]    bit_cnt, cnt_nxt;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             accept;
    logic [WIDTH-1:0] dout_nxt;
    logic             valid_nxt;
    logic             ovf_nxt;
`ifdef SIPO_PARITY_EN
    logic             par_fail;
    logic             perr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            ovf        <= ovf_nxt;
`ifdef SIPO_PARITY_EN
            perr_q     <= par_fail;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        word      = shift_reg;
        word_done = 1'b0;
`ifdef SIPO_PARITY_EN
        par_fail  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sin) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                shift_nxt = {shift_reg[WIDTH-2:0], sin};
                cnt_nxt   = bit_cnt + CW'(1);
                if (bit_cnt == CW'(WIDTH - 1)) begin
                    cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
                    word_done = 1'b1;
                    word      = shift_nxt;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
                if ((^shift_reg) == sin) begin
                    word_done = 1'b1;
                    word      = shift_reg;
                end else begin
                    par_fail = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A completing word may land in the buffer on the same edge the consumer drains it.
    always_comb begin
        accept    = word_done && (!dout_valid || dout_ready);
        dout_nxt  = dout;
        valid_nxt = dout_valid;
        ovf_nxt   = word_done && !accept;
        if (accept) begin
            dout_nxt  = word;
            valid_nxt = 1'b1;
        end else if (dout_valid && dout_ready) begin
            valid_nxt = 1'b0;
        end
    end

    assign busy = (state != IDLE);

`ifdef SIPO_PARITY_EN
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
